// File: rtl/mux8way_scan_pkg.sv
// Shared types for the eight-lane round-robin serializer.
package mux8way_pkg;

    localparam int LANES = 8;

    typedef logic [2:0] lane_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/mux8way_scan_rr_pick8.sv
// Combinational round-robin picker: first pending lane at or after start, wrapping 7->0.
import mux8way_pkg::*;

module rr_pick8 (
    input  logic [LANES-1:0] pend,
    input  lane_idx_t        start,
    output logic             found,
    output lane_idx_t        idx
);

    lane_idx_t lane_s;

    // Scan from farthest offset down to offset 0 so the nearest pending lane wins.
    always_comb begin
        found  = 1'b0;
        idx    = 3'd0;
        lane_s = 3'd0;
        for (int k = LANES - 1; k >= 0; k--) begin
            lane_s = start + 3'(k);
            if (pend[lane_s]) begin
                found = 1'b1;
                idx   = lane_s;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/mux8way_scan.sv
// Eight lane one-entry holders serialized round-robin onto out/sel with valid/ready.
// Optional MUX8WAY_SCAN_OVF_EN: drop colliding requests and pulse ovf instead of overwriting.
import mux8way_pkg::*;

module mux8way_scan (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             e,
    input  logic             f,
    input  logic             g,
    input  logic             h,
    input  logic [LANES-1:0] req,
    input  logic             ready,
    output logic             out,
    output logic [2:0]       sel,
    output logic             valid,
    output logic             ovf
);

    logic [LANES-1:0] lanes_s;
    logic [LANES-1:0] pend_q, pend_d;
    logic [LANES-1:0] dat_q, dat_d;
    logic [LANES-1:0] ovf_hit_s;
    state_t           state_q, state_d;
    lane_idx_t        sel_q, sel_d;
    lane_idx_t        ptr_q, ptr_d;
    logic             out_q, out_d;
    logic             ovf_q, ovf_d;
    logic             found_s;
    lane_idx_t        gidx_s;
    logic             take_s;
    logic             granted_s;

    assign lanes_s = {h, g, f, e, d, c, b, a};

    rr_pick8 u_pick (
        .pend  (pend_q),
        .start (ptr_q),
        .found (found_s),
        .idx   (gidx_s)
    );

    // Output FSM: decide whether a grant is taken this edge and what out/sel become.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        out_d   = out_q;
        ptr_d   = ptr_q;
        take_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    take_s  = 1'b1;
                    state_d = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (ready) begin
                    if (found_s) begin
                        take_s  = 1'b1;
                        state_d = HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (take_s) begin
            sel_d = gidx_s;
            out_d = dat_q[gidx_s];
            ptr_d = gidx_s + 3'd1;
        end else begin
            sel_d = sel_q;
        end
    end

    // Lane holders: a grant reads the old bit, so a same-edge request simply refills the slot.
    always_comb begin
        pend_d    = pend_q;
        dat_d     = dat_q;
        ovf_hit_s = {LANES{1'b0}};
        granted_s = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            granted_s = take_s && (gidx_s == 3'(i));
            if (req[i]) begin
                if (pend_q[i] && !granted_s) begin
`ifdef MUX8WAY_SCAN_OVF_EN
                    ovf_hit_s[i] = 1'b1;
`else
                    dat_d[i] = lanes_s[i];
`endif
                end else begin
                    pend_d[i] = 1'b1;
                    dat_d[i]  = lanes_s[i];
                end
            end else if (granted_s) begin
                pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = pend_q[i];
            end
        end
`ifdef MUX8WAY_SCAN_OVF_EN
        ovf_d = |ovf_hit_s;
`else
        ovf_d = 1'b0;
`endif
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= {LANES{1'b0}};
            dat_q   <= {LANES{1'b0}};
            sel_q   <= 3'd0;
            ptr_q   <= 3'd0;
            out_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out   = out_q;
    assign sel   = sel_q;
    assign valid = (state_q == HOLD);
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_mux8way_scan.sv
// Directed self-checking bench for mux8way_scan.
module tb_mux8way_scan;

    logic       clk;
    logic       rst_n;
    logic [7:0] lanes;
    logic [7:0] req;
    logic       ready;
    logic       out;
    logic [2:0] sel;
    logic       valid;
    logic       ovf;

    int checks;
    int failures;

`ifdef MUX8WAY_SCAN_OVF_EN
    localparam logic EXP_OVF  = 1'b1;
    localparam logic EXP_OUT3 = 1'b1;
`else
    localparam logic EXP_OVF  = 1'b0;
    localparam logic EXP_OUT3 = 1'b0;
`endif

    mux8way_scan dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (lanes[0]),
        .b     (lanes[1]),
        .c     (lanes[2]),
        .d     (lanes[3]),
        .e     (lanes[4]),
        .f     (lanes[5]),
        .g     (lanes[6]),
        .h     (lanes[7]),
        .req   (req),
        .ready (ready),
        .out   (out),
        .sel   (sel),
        .valid (valid),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        lanes = 8'h00;
        ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        rst_n    = 1'b0;
        req      = 8'h00;
        lanes    = 8'h00;
        ready    = 1'b0;

        // single word on lane a
        do_reset();
        check_val("rst_valid", {7'd0, valid}, 8'd0);
        check_val("rst_sel", {5'd0, sel}, 8'd0);
        check_val("rst_out", {7'd0, out}, 8'd0);
        check_val("rst_ovf", {7'd0, ovf}, 8'd0);
        lanes = 8'h01; req = 8'h01; ready = 1'b1;
        tick();
        req = 8'h00; lanes = 8'h00;
        check_val("a_latency", {7'd0, valid}, 8'd0);
        tick();
        check_val("a_valid", {7'd0, valid}, 8'd1);
        check_val("a_sel", {5'd0, sel}, 8'd0);
        check_val("a_out", {7'd0, out}, 8'd1);
        tick();
        check_val("a_idle", {7'd0, valid}, 8'd0);

        // all eight lanes at once, alternating data
        do_reset();
        lanes = 8'h55; req = 8'hFF; ready = 1'b1;
        tick();
        req = 8'h00; lanes = 8'h00;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_val($sformatf("ff_valid%0d", k), {7'd0, valid}, 8'd1);
            check_val($sformatf("ff_sel%0d", k), {5'd0, sel}, 8'(k));
            check_val($sformatf("ff_out%0d", k), {7'd0, out}, (k % 2 == 0) ? 8'd1 : 8'd0);
        end
        tick();
        check_val("ff_idle", {7'd0, valid}, 8'd0);

        // backpressure on c while f waits
        do_reset();
        lanes = 8'h24; req = 8'h24; ready = 1'b0;
        tick();
        req = 8'h00; lanes = 8'h00;
        tick();
        check_val("bp_sel_c", {5'd0, sel}, 8'd2);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val($sformatf("bp_hold_valid%0d", k), {7'd0, valid}, 8'd1);
            check_val($sformatf("bp_hold_sel%0d", k), {5'd0, sel}, 8'd2);
            check_val($sformatf("bp_hold_out%0d", k), {7'd0, out}, 8'd1);
        end
        ready = 1'b1;
        tick();
        check_val("bp_sel_f", {5'd0, sel}, 8'd5);
        check_val("bp_valid_f", {7'd0, valid}, 8'd1);
        tick();
        check_val("bp_idle", {7'd0, valid}, 8'd0);

        // wrap from g through h to a
        do_reset();
        req = 8'h40; ready = 1'b0;
        tick();
        req = 8'h00;
        tick();
        check_val("wr_sel_g", {5'd0, sel}, 8'd6);
        check_val("wr_out_g", {7'd0, out}, 8'd0);
        lanes = 8'h81; req = 8'h81;
        tick();
        req = 8'h00; lanes = 8'h00; ready = 1'b1;
        tick();
        check_val("wr_sel_h", {5'd0, sel}, 8'd7);
        check_val("wr_out_h", {7'd0, out}, 8'd1);
        tick();
        check_val("wr_sel_a", {5'd0, sel}, 8'd0);
        check_val("wr_out_a", {7'd0, out}, 8'd1);
        tick();
        check_val("wr_idle", {7'd0, valid}, 8'd0);

        // repeated request on a pending, ungranted lane d
        do_reset();
        lanes = 8'h01; req = 8'h01; ready = 1'b0;
        tick();
        req = 8'h00; lanes = 8'h00;
        tick();
        check_val("ov_sel_a", {5'd0, sel}, 8'd0);
        lanes = 8'h08; req = 8'h08;
        tick();
        check_val("ov_none_yet", {7'd0, ovf}, 8'd0);
        lanes = 8'h00; req = 8'h08;
        tick();
        check_val("ov_pulse", {7'd0, ovf}, {7'd0, EXP_OVF});
        req = 8'h00;
        tick();
        check_val("ov_pulse_end", {7'd0, ovf}, 8'd0);
        ready = 1'b1;
        tick();
        check_val("ov_sel_d", {5'd0, sel}, 8'd3);
        check_val("ov_out_d", {7'd0, out}, {7'd0, EXP_OUT3});
        tick();
        check_val("ov_idle", {7'd0, valid}, 8'd0);

        // reset mid-operation discards everything
        do_reset();
        lanes = 8'hFF; req = 8'h52; ready = 1'b0;
        tick();
        req = 8'h00;
        tick();
        check_val("mr_valid", {7'd0, valid}, 8'd1);
        check_val("mr_sel_b", {5'd0, sel}, 8'd1);
        rst_n = 1'b0; req = 8'hFF;
        tick();
        check_val("mr_rst_valid", {7'd0, valid}, 8'd0);
        check_val("mr_rst_sel", {5'd0, sel}, 8'd0);
        check_val("mr_rst_out", {7'd0, out}, 8'd0);
        rst_n = 1'b1; req = 8'h00; ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val($sformatf("mr_quiet%0d", k), {7'd0, valid}, 8'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux8way_scan.md
MUX8WAY_SCAN -- requirements
Module: mux8way_scan

Interface
REQ-001 Parameter: none; lane count fixed at 8 (a..h, lane index 0..7 = a..h).
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 a,b,c,d,e,f,g,h  input  1 each  lane data bits.
REQ-005 req  input  8  per-lane strobe; req[i]=1 means the lane i data bit is valid this cycle.
REQ-006 out  output  1  serialized data bit.
REQ-007 sel  output  3  lane index of out (000=a ... 111=h), the same encoding a DMux8Way consumer uses to route out back.
REQ-008 valid  output  1  out/sel hold a word.
REQ-009 ready  input  1  consumer accepts the word when valid&&ready at a rising edge.
REQ-010 ovf  output  1  one-cycle pulse on lane overflow (see Configuration).

Function
REQ-011 Each lane SHALL have a one-entry hold register (pend[i], dat[i]); req[i]=1 at an edge sets pend[i] and captures the lane bit.
REQ-012 Output register SHALL be a two-state FSM: IDLE (valid=0), HOLD (valid=1).
REQ-013 IDLE->HOLD when any pend is set; the granted lane's dat/index load into out/sel and its pend clears, same edge.
REQ-014 HOLD with ready=1: if any pend set, reload next grant (stay HOLD, back-to-back, 1 word/cycle); else ->IDLE, out/sel unchanged.
REQ-015 HOLD with ready=0: out, sel, valid SHALL stay stable; no grant.
REQ-016 Grant SHALL be round-robin: search starts at lane (last granted index + 1) mod 8, wrapping 7->0.
REQ-017 Latency: req[i] at edge N -> earliest valid with sel=i after edge N+1 (registered path, no combinational req->out).
REQ-018 Same-edge grant of lane i and new req[i]: grant takes the old dat[i]; pend[i] stays set holding the new bit; no overflow.
REQ-019 Multiple simultaneous req bits SHALL all be captured in one cycle.

Reset
REQ-020 rst_n=0 at an edge: valid=0, out=0, sel=000, ovf=0, all pend=0, all dat=0, round-robin pointer so lane a is searched first, FSM=IDLE.
REQ-021 Reset mid-operation SHALL discard held and pending words; req during the reset cycle is ignored.

Configuration
REQ-022 Macro MUX8WAY_SCAN_OVF_EN defined: req[i] on lane with pend[i]=1 not being granted SHALL be dropped (old bit kept) and ovf SHALL pulse 1 for one cycle.
REQ-023 MUX8WAY_SCAN_OVF_EN undefined: such a req SHALL overwrite dat[i]; ovf SHALL be tied 0.

Structure
REQ-024 Package mux8way_pkg SHALL hold LANES=8, lane-index typedef (3 bits), FSM state enum {IDLE, HOLD}.
REQ-025 Sub-module rr_pick8 (combinational: pend[7:0], start index -> grant found, grant index) SHALL implement REQ-016.

Verification
REQ-026 Reset then req=8'b0000_0001, a=1, ready=1 -> valid=1, sel=000, out=1 one cycle later; then valid=0.
REQ-027 req=8'hFF with a..h=1,0,1,0,1,0,1,0, ready=1 -> 8 consecutive valid words sel=000..111, out=1,0,1,0,1,0,1,0, then IDLE.
REQ-028 Lanes c and f pending, ready=0 for 5 cycles -> out/sel frozen on sel=010; ready=1 -> sel=101 next cycle.
REQ-029 Last grant sel=110, pend on a and h -> next grant sel=111, then sel=000 (wrap).
REQ-030 With OVF_EN, ready=0, req[3] twice with d=1 then d=0 -> ovf pulses once, later word sel=011 out=1; without OVF_EN out=0, ovf=0.
REQ-031 rst_n=0 while valid=1 and 3 lanes pending -> next cycle valid=0, sel=000, no further words without new req.
